// File: rtl/hbridge_drive_pkg.sv
// Shared definitions for the H-bridge output stage: state encoding,
// direction constants and the counter width.
package hbd_pkg;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    COAST = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2,
    BRAKE = 2'd3
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
endpackage

// File: rtl/hbridge_drive_if.sv
// Control inputs from the cycle generator and L298-style bridge outputs.
interface hbridge_drive_if;
  logic ZF;
  logic SP;
  logic EN;
  logic IN1;
  logic IN2;
  logic ENA;
  logic ACTIVE;

  modport master (output ZF, SP, EN, input IN1, IN2, ENA, ACTIVE);
  modport slave  (input ZF, SP, EN, output IN1, IN2, ENA, ACTIVE);
endinterface

// File: rtl/hbridge_pwm.sv
// PWM generator: period counter, duty latched at each period start, registered compare.
module hbridge_pwm
  import hbd_pkg::*;
#(
  parameter int PWM_PERIOD = 400,
  parameter int FAST_DUTY  = 300,
  parameter int SLOW_DUTY  = 120
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic RUN,
  input  logic SP,
  output logic PWM_OUT
);
  localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] FAST = CW'(FAST_DUTY);
  localparam logic [CW-1:0] SLOW = CW'(SLOW_DUTY);

  logic [CW-1:0] cnt_q, cnt_n, duty_q, duty_n;
  logic          run_q;

  // RUN is the FSM's next-state view, so the first running cycle sits at count 0
  always_comb begin
    cnt_n  = (run_q && cnt_q != LAST) ? cnt_q + CW'(1) : '0;
    duty_n = (cnt_n == '0) ? (SP ? FAST : SLOW) : duty_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      run_q   <= 1'b0;
      PWM_OUT <= 1'b0;
    end else if (!RUN) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      run_q   <= 1'b0;
      PWM_OUT <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      duty_q  <= duty_n;
      run_q   <= 1'b1;
      PWM_OUT <= (cnt_n < duty_n);
    end
  end
endmodule

// File: rtl/hbridge_drive.sv
// H-bridge output stage: dead-time on start/reversal, SP-selected PWM on ENA.
// Define HBD_BRAKE_EN to short-brake (1/1/1) for BRAKE_CYC cycles on drive stop.
module hbridge_drive
  import hbd_pkg::*;
#(
  parameter int PWM_PERIOD = 400,
  parameter int FAST_DUTY  = 300,
  parameter int SLOW_DUTY  = 120,
  parameter int DEAD_CYC   = 50,
  parameter int BRAKE_CYC  = 200
) (
  input  logic          CLK,
  input  logic          RSTN,
  hbridge_drive_if.slave bus
);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          in1_q, in2_q, act_q, pwm_out;
`ifdef HBD_BRAKE_EN
  localparam logic [CW-1:0] BRAKE_LAST = CW'(BRAKE_CYC - 1);
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          brk_q;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dcnt_d  = '0;
`ifdef HBD_BRAKE_EN
    bcnt_d  = '0;
`endif
    case (state_q)
      COAST: if (bus.EN) begin
        state_d = DEAD;
        dir_d   = bus.ZF;
      end
      DEAD: begin
        if (!bus.EN)                 state_d = COAST;
        else if (bus.ZF != dir_q)    dir_d   = bus.ZF;  // retarget, dead-time restarts
        else if (dcnt_q == DEAD_LAST) state_d = DRIVE;
        else                         dcnt_d  = dcnt_q + CW'(1);
      end
      DRIVE: begin
        if (!bus.EN) begin
`ifdef HBD_BRAKE_EN
          state_d = BRAKE;
`else
          state_d = COAST;
`endif
        end else if (bus.ZF != dir_q) begin
          state_d = DEAD;
          dir_d   = bus.ZF;
        end
      end
`ifdef HBD_BRAKE_EN
      BRAKE: begin
        if (bus.EN) begin
          state_d = DEAD;
          dir_d   = bus.ZF;
        end else if (bcnt_q == BRAKE_LAST) state_d = COAST;
        else bcnt_d = bcnt_q + CW'(1);
      end
`endif
      default: state_d = COAST;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= COAST;
      dir_q   <= DIR_REV;
      dcnt_q  <= '0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      act_q   <= 1'b0;
`ifdef HBD_BRAKE_EN
      bcnt_q  <= '0;
      brk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dcnt_q  <= dcnt_d;
      act_q   <= (state_d == DRIVE);
`ifdef HBD_BRAKE_EN
      bcnt_q  <= bcnt_d;
      brk_q   <= (state_d == BRAKE);
      in1_q   <= (state_d == BRAKE) || (state_d == DRIVE && dir_d == DIR_FWD);
      in2_q   <= (state_d == BRAKE) || (state_d == DRIVE && dir_d == DIR_REV);
`else
      in1_q   <= (state_d == DRIVE && dir_d == DIR_FWD);
      in2_q   <= (state_d == DRIVE && dir_d == DIR_REV);
`endif
    end
  end

  hbridge_pwm #(
    .PWM_PERIOD(PWM_PERIOD),
    .FAST_DUTY (FAST_DUTY),
    .SLOW_DUTY (SLOW_DUTY)
  ) u_pwm (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .RUN    (state_d == DRIVE),
    .SP     (bus.SP),
    .PWM_OUT(pwm_out)
  );

  assign bus.IN1    = in1_q;
  assign bus.IN2    = in2_q;
  assign bus.ACTIVE = act_q;
`ifdef HBD_BRAKE_EN
  assign bus.ENA    = pwm_out | brk_q;
`else
  assign bus.ENA    = pwm_out;
`endif
endmodule
